// File: rtl/dir_input_queue.sv
// -----------------------------------------------------------------------------
// dir_input_queue
//
// Small FIFO of direction presses that sits between the press debouncers and
// the snake game state machine. Two presses arriving inside one game tick are
// both kept and are applied on successive ticks, in order. A press that
// repeats or reverses the most recently accepted direction is discarded.
//
// Optional build macro: DIR_QUEUE_STATS_EN
//   defined   -> DropCount is an 8-bit saturating count of every discarded
//                press (filtered or overflow), cleared only by Reset.
//   undefined -> DropCount is tied to 0.
//
// Ports:
//   Clock         game clock
//   Reset         synchronous, active-high; overrides everything else
//   LeftPressed   one-cycle debounced press pulses; when several are high
//   RightPressed  together the priority is Left > Right > Up > Down
//   UpPressed
//   DownPressed
//   Tick          game-step strobe; pops one entry into Dir
//   Flush         game restart; empties the queue and loads InitDir
//   InitDir       direction loaded into Dir / last-accepted on Flush
//   HeadDir       combinational: direction the game uses this cycle
//   Dir           registered committed direction
//   Count         number of queued entries
//   Empty, Full   decoded from Count
//   Dropped       one-cycle pulse when a press is lost to a full queue
//   DropCount     discarded-press statistics (see macro above)
// -----------------------------------------------------------------------------
`ifndef BITS_PER_DIR
`define BITS_PER_DIR 2
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module dir_input_queue #(
  parameter int DEPTH    = 4,
  parameter int DIR_BITS = `BITS_PER_DIR
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       LeftPressed,
  input  logic                       RightPressed,
  input  logic                       UpPressed,
  input  logic                       DownPressed,
  input  logic                       Tick,
  input  logic                       Flush,
  input  logic [DIR_BITS-1:0]        InitDir,
  output logic [DIR_BITS-1:0]        HeadDir,
  output logic [DIR_BITS-1:0]        Dir,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty,
  output logic                       Full,
  output logic                       Dropped,
  output logic [7:0]                 DropCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [DIR_BITS-1:0] UP_D    = DIR_BITS'(`DIR_UP);
  localparam logic [DIR_BITS-1:0] DOWN_D  = DIR_BITS'(`DIR_DOWN);
  localparam logic [DIR_BITS-1:0] LEFT_D  = DIR_BITS'(`DIR_LEFT);
  localparam logic [DIR_BITS-1:0] RIGHT_D = DIR_BITS'(`DIR_RIGHT);

  function automatic logic isOpposite(input logic [DIR_BITS-1:0] a,
                                      input logic [DIR_BITS-1:0] b);
    return ((a == UP_D)   && (b == DOWN_D))  || ((a == DOWN_D)  && (b == UP_D)) ||
           ((a == LEFT_D) && (b == RIGHT_D)) || ((a == RIGHT_D) && (b == LEFT_D));
  endfunction

  logic [DIR_BITS-1:0] slots [DEPTH];
  logic [PW-1:0]       rdPtr;
  logic [PW-1:0]       wrPtr;
  logic [DIR_BITS-1:0] lastDir;

  logic                candValid;
  logic [DIR_BITS-1:0] candDir;
  logic                filterPass;
  logic                pop;
  logic                push;
  logic                overflowDrop;

  // Press decode: one candidate per cycle, fixed priority.
  always_comb begin
    candValid = 1'b1;
    candDir   = LEFT_D;
    if (LeftPressed)       candDir = LEFT_D;
    else if (RightPressed) candDir = RIGHT_D;
    else if (UpPressed)    candDir = UP_D;
    else if (DownPressed)  candDir = DOWN_D;
    else                   candValid = 1'b0;
  end

  // Filtering is against lastDir as it stood before this cycle, so a press
  // coinciding with a pop still sees the newest accepted direction.
  assign filterPass   = candValid && (candDir != lastDir) && !isOpposite(candDir, lastDir);
  assign pop          = Tick && (Count != '0);
  // A full queue still accepts a press when the same cycle frees a slot.
  assign push         = filterPass && ((Count != DEPTH_C) || pop);
  assign overflowDrop = filterPass && !push;

  assign Empty   = (Count == '0);
  assign Full    = (Count == DEPTH_C);
  assign HeadDir = Empty ? Dir : slots[rdPtr];

  // Queue storage: data only, no reset; validity is tracked by Count.
  always_ff @(posedge Clock) begin
    if (push && !Flush) slots[wrPtr] <= candDir;
  end

  // Control state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      Count   <= '0;
      Dir     <= RIGHT_D;
      lastDir <= RIGHT_D;
      Dropped <= 1'b0;
    end else if (Flush) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      Count   <= '0;
      Dir     <= InitDir;
      lastDir <= InitDir;
      Dropped <= 1'b0;
    end else begin
      Dropped <= overflowDrop;
      if (push) begin
        wrPtr   <= wrPtr + PW'(1);
        lastDir <= candDir;
      end
      if (pop) begin
        Dir   <= slots[rdPtr];
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

`ifdef DIR_QUEUE_STATS_EN
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic filteredDrop;
  assign filteredDrop = candValid && !filterPass;

  // Flush ignores presses, so nothing is counted in a Flush cycle.
  always_ff @(posedge Clock) begin
    if (Reset)
      DropCount <= 8'd0;
    else if (!Flush && (filteredDrop || overflowDrop))
      DropCount <= satInc(DropCount);
  end
`else
  assign DropCount = 8'd0;
`endif

endmodule

// File: tb/tb_dir_input_queue.sv
`timescale 1ns/1ps
`ifndef BITS_PER_DIR
`define BITS_PER_DIR 2
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module tb_dir_input_queue;
  localparam int DEPTH = 4;
  localparam int DB    = `BITS_PER_DIR;
  localparam logic [DB-1:0] UP    = DB'(`DIR_UP);
  localparam logic [DB-1:0] DOWN  = DB'(`DIR_DOWN);
  localparam logic [DB-1:0] LEFT  = DB'(`DIR_LEFT);
  localparam logic [DB-1:0] RIGHT = DB'(`DIR_RIGHT);

  logic          Clock = 1'b0;
  logic          Reset, LeftPressed, RightPressed, UpPressed, DownPressed;
  logic          Tick, Flush;
  logic [DB-1:0] InitDir;
  logic [DB-1:0] HeadDir, Dir;
  logic [$clog2(DEPTH):0] Count;
  logic          Empty, Full, Dropped;
  logic [7:0]    DropCount;

  int nCompared   = 0;
  int nMismatched = 0;
  int expDrop     = 0;

  dir_input_queue #(.DEPTH(DEPTH), .DIR_BITS(DB)) dut (
    .Clock(Clock), .Reset(Reset),
    .LeftPressed(LeftPressed), .RightPressed(RightPressed),
    .UpPressed(UpPressed), .DownPressed(DownPressed),
    .Tick(Tick), .Flush(Flush), .InitDir(InitDir),
    .HeadDir(HeadDir), .Dir(Dir), .Count(Count),
    .Empty(Empty), .Full(Full), .Dropped(Dropped), .DropCount(DropCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkDropCount(input string tag);
`ifdef DIR_QUEUE_STATS_EN
    check(tag, DropCount, expDrop);
`else
    check(tag, DropCount, 0);
`endif
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Hold the given inputs for one clock edge, then release them.
  task automatic drive(input logic l, input logic r, input logic u, input logic d,
                       input logic t, input logic f, input logic rst);
    LeftPressed = l; RightPressed = r; UpPressed = u; DownPressed = d;
    Tick = t; Flush = f; Reset = rst;
    step();
    LeftPressed = 0; RightPressed = 0; UpPressed = 0; DownPressed = 0;
    Tick = 0; Flush = 0; Reset = 0;
  endtask

  task automatic doReset();
    drive(0, 0, 0, 0, 0, 0, 1);
    expDrop = 0;
  endtask

  task automatic fillUpLeftDownRight();
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  logic [DB-1:0] seqA [4];
  logic [DB-1:0] seqB [4];

  initial begin
    seqA[0] = UP;   seqA[1] = LEFT; seqA[2] = DOWN;  seqA[3] = RIGHT;
    seqB[0] = LEFT; seqB[1] = DOWN; seqB[2] = RIGHT; seqB[3] = UP;
    LeftPressed = 0; RightPressed = 0; UpPressed = 0; DownPressed = 0;
    Tick = 0; Flush = 0; InitDir = RIGHT; Reset = 1;

    // Reset state
    doReset();
    check("rst_count", Count, 0);
    check("rst_dir", Dir, RIGHT);
    check("rst_head", HeadDir, RIGHT);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_dropped", Dropped, 0);
    checkDropCount("rst_dropcount");

    // Single press then tick
    drive(0, 0, 1, 0, 0, 0, 0);
    check("up_count", Count, 1);
    check("up_head", HeadDir, UP);
    check("up_dir", Dir, RIGHT);
    check("up_empty", Empty, 0);
    Tick = 1;
    check("tick_head_sample", HeadDir, UP);
    Tick = 0;
    drive(0, 0, 0, 0, 1, 0, 0);
    check("tick_dir", Dir, UP);
    check("tick_count", Count, 0);
    check("tick_empty", Empty, 1);

    // Reversal and repeat are filtered silently
    doReset();
    drive(1, 0, 0, 0, 0, 0, 0);
    expDrop++;
    check("rev_count", Count, 0);
    check("rev_dropped", Dropped, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    expDrop++;
    check("rep_count", Count, 0);
    check("rep_dropped", Dropped, 0);
    checkDropCount("filter_dropcount");

    // Fill to full, overflow, drain in order
    doReset();
    fillUpLeftDownRight();
    check("fill_count", Count, 4);
    check("fill_full", Full, 1);
    check("fill_head", HeadDir, UP);
    drive(0, 0, 1, 0, 0, 0, 0);
    expDrop++;
    check("ovf_dropped", Dropped, 1);
    check("ovf_count", Count, 4);
    step();
    check("ovf_dropped_clear", Dropped, 0);
    checkDropCount("ovf_dropcount");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check($sformatf("drainA_dir%0d", i), Dir, seqA[i]);
    end
    check("drainA_empty", Empty, 1);

    // Full queue: press coinciding with a pop is accepted
    fillUpLeftDownRight();
    check("refill_full", Full, 1);
    drive(0, 0, 1, 0, 1, 0, 0);
    check("pushpop_count", Count, 4);
    check("pushpop_dropped", Dropped, 0);
    check("pushpop_dir", Dir, UP);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check($sformatf("drainB_dir%0d", i), Dir, seqB[i]);
    end
    checkDropCount("pushpop_dropcount");

    // Priority: Left beats Down, Dir=UP
    check("prio_pre_dir", Dir, UP);
    drive(1, 0, 0, 1, 0, 0, 0);
    check("prio_count", Count, 1);
    check("prio_head", HeadDir, LEFT);
    checkDropCount("prio_dropcount");

    // Three entries, Flush with Tick and a press in the same cycle
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    check("three_count", Count, 3);
    InitDir = RIGHT;
    drive(0, 0, 0, 1, 1, 1, 0);
    check("flush_count", Count, 0);
    check("flush_dir", Dir, RIGHT);
    check("flush_head", HeadDir, RIGHT);
    check("flush_dropped", Dropped, 0);
    checkDropCount("flush_dropcount");

    // Flush loads the filter reference
    InitDir = LEFT;
    drive(0, 0, 0, 0, 0, 1, 0);
    check("flush2_dir", Dir, LEFT);
    drive(0, 1, 0, 0, 0, 0, 0);
    expDrop++;
    check("flush2_rev_count", Count, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("flush2_up_count", Count, 1);
    checkDropCount("flush2_dropcount");

    // Reset during a push
    drive(0, 0, 0, 1, 0, 0, 1);
    expDrop = 0;
    check("rstpush_count", Count, 0);
    check("rstpush_dir", Dir, RIGHT);
    check("rstpush_empty", Empty, 1);
    checkDropCount("rstpush_dropcount");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/dir_input_queue.md
Name: dir_input_queue

Overview:
- Buffers debounced direction presses between the Debouncer instances and the snake game state machine, so that two quick presses inside one game tick are both honoured in order instead of the later one overwriting the earlier.
- Filters out repeats and reversals against the most recently accepted direction.
- Pops one direction per game tick and presents the direction the game must use on that tick.

Parameters:
- DEPTH, 4, number of queued directions; power of two, ≥2.
- DIR_BITS, `BITS_PER_DIR, direction width; encodings are the `DIR_UP/`DIR_DOWN/`DIR_LEFT/`DIR_RIGHT macros from Constants.v.

Ports:
- Clock  input  1  system clock (the divided clock the game logic runs on).
- Reset  input  1  synchronous, active-high reset.
- LeftPressed  input  1  single-cycle debounced press pulse.
- RightPressed  input  1  single-cycle debounced press pulse.
- UpPressed  input  1  single-cycle debounced press pulse.
- DownPressed  input  1  single-cycle debounced press pulse.
- Tick  input  1  game-step strobe (gameClock); consumes one entry.
- Flush  input  1  game restart; clears queue and loads InitDir.
- InitDir  input  DIR_BITS  direction loaded on Flush.
- HeadDir  output  DIR_BITS  combinational; direction the game uses this cycle.
- Dir  output  DIR_BITS  registered committed direction.
- Count  output  $clog2(DEPTH)+1  entries held.
- Empty  output  1  Count==0.
- Full  output  1  Count==DEPTH.
- Dropped  output  1  one-cycle pulse when a press is discarded because the queue is full.
- DropCount  output  8  see Optional Feature.

Behaviour:
- Reset (synchronous):
  - Queue empty; read/write pointers 0; Count=0.
  - Dir=`DIR_RIGHT and LastDir=`DIR_RIGHT, where LastDir is an internal register holding the last accepted direction.
  - Dropped=0, DropCount=0.
  - Reset overrides Flush, Tick and presses in the same cycle.
- Press decode:
  - If several press inputs are high in one cycle, the candidate is chosen by priority Left > Right > Up > Down.
  - At most one candidate per cycle.
- Filter: a candidate is discarded silently (no Dropped pulse) if it equals LastDir or is the opposite of LastDir (UP/DOWN, LEFT/RIGHT).
- Push:
  - A filtered candidate is written at the write pointer when Count<DEPTH, or when Count==DEPTH and Tick pops in the same cycle.
  - On push, LastDir <= candidate.
  - Otherwise the candidate is dropped, Dropped=1 for that cycle, and LastDir is unchanged.
- HeadDir: equals the queue head entry when non-empty, else Dir. It is purely combinational from state and has no input dependence.
- Pop:
  - On Tick with Count>0: Dir <= head entry and the read pointer advances.
  - On Tick with Count==0: no change.
  - The game samples HeadDir in the Tick cycle; Dir reflects the same value on the next cycle.
- Simultaneous Tick and push:
  - Pop and push both occur; Count is unchanged.
  - The filter compares against LastDir as it stood before the cycle.
- Pointers wrap modulo DEPTH. Count is computed as Count + push − pop and never exceeds DEPTH or goes below 0.
- Flush (when Reset=0):
  - Queue empty, Dir <= InitDir, LastDir <= InitDir.
  - Presses and Tick in the same cycle are ignored.
  - Dropped=0.
- Flush does not clear DropCount.
- All outputs except HeadDir, Empty and Full are registered. Empty and Full decode from Count.

Optional Feature:
- Macro: DIR_QUEUE_STATS_EN.
- Defined: DropCount is an 8-bit saturating counter (holds at 255).
  - Increments by 1 for every discarded candidate, both filtered and overflow.
  - Cleared only by Reset.
- Undefined: DropCount is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then a single UpPressed pulse -> Count=1, HeadDir=UP, Dir=RIGHT; Tick -> next cycle Dir=UP, Count=0, Empty=1.
- From Dir=RIGHT: LeftPressed, then RightPressed -> both discarded, Count=0, Dropped never asserted; with DIR_QUEUE_STATS_EN, DropCount=2.
- DEPTH=4: push UP, LEFT, DOWN, RIGHT -> Full=1. Then UpPressed -> Dropped pulses 1 cycle, Count stays 4. Four Ticks -> Dir sequence UP, LEFT, DOWN, RIGHT.
- Full queue, UpPressed and Tick in the same cycle -> push accepted, Count stays 4, Dropped=0, tail entry=UP.
- LeftPressed and DownPressed in the same cycle with Dir=UP -> only LEFT enqueued, Count=1.
- Queue holding 3 entries, Flush with InitDir=RIGHT plus a concurrent Tick -> Count=0, Dir=RIGHT, HeadDir=RIGHT. Then Reset asserted during a push -> Count=0, Dir=RIGHT.
